// File: rtl/key_expansion_seq_if.sv
// Handshake and schedule bus for the AES-128 key schedule generator.
interface key_expansion_seq_if #(
    parameter int ROUNDS = 10
);
    logic                          start;
    logic [127:0]                  cipher_key;
    logic [128*(ROUNDS+1)-1:0]     key_schedule;
    logic                          busy;
    logic                          done;
    logic                          key_valid;

    modport master (
        output start, cipher_key,
        input  key_schedule, busy, done, key_valid
    );

    modport slave (
        input  start, cipher_key,
        output key_schedule, busy, done, key_valid
    );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slice schedule.
// Define KEYEXP_SBOX_PIPE_EN to register SubWord, making each round take two clocks.
module key_expansion_seq #(
    parameter int ROUNDS = 10
) (
    input logic           Clk,
    input logic           Reset,
    key_expansion_seq_if.slave kx
);
    localparam int         SCHED_W  = 128*(ROUNDS+1);
    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t               state, state_next;
    logic [3:0]           rnd;
    logic [127:0]         prev_key;
    logic [SCHED_W-1:0]   sched;
    logic                 busy_r, done_r, valid_r;
    logic                 load, write_slice;
    logic [31:0]          temp_comb, temp_use;
    logic [127:0]         next_key;
`ifdef KEYEXP_SBOX_PIPE_EN
    logic                 phase;
    logic [31:0]          temp_p1;
`endif

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 via an addition chain, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign temp_comb = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon(rnd), 24'h0};
`ifdef KEYEXP_SBOX_PIPE_EN
    assign temp_use  = temp_p1;
`else
    assign temp_use  = temp_comb;
`endif

    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0       = prev_key[127:96] ^ temp_use;
        w1       = prev_key[95:64]  ^ w0;
        w2       = prev_key[63:32]  ^ w1;
        w3       = prev_key[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        write_slice = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (kx.start) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
`ifdef KEYEXP_SBOX_PIPE_EN
                write_slice = phase;
`else
                write_slice = 1'b1;
`endif
                if (write_slice && rnd == LAST_RND) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage boundary: schedule slices, chaining key and status flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sched    <= '0;
            prev_key <= '0;
            rnd      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
            phase    <= 1'b0;
            temp_p1  <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            if (load) begin
                sched    <= {{(SCHED_W-128){1'b0}}, kx.cipher_key};
                prev_key <= kx.cipher_key;
                rnd      <= 4'd1;
                busy_r   <= 1'b1;
                valid_r  <= 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
                phase    <= 1'b0;
`endif
            end else if (state == EXPAND) begin
`ifdef KEYEXP_SBOX_PIPE_EN
                if (!phase) begin
                    temp_p1 <= temp_comb;
                    phase   <= 1'b1;
                end else begin
                    phase   <= 1'b0;
                end
`endif
                if (write_slice) begin
                    sched[128*rnd +: 128] <= next_key;
                    prev_key              <= next_key;
                    if (rnd == LAST_RND) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        valid_r <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
            end
        end
    end

    assign kx.key_schedule = sched;
    assign kx.busy         = busy_r;
    assign kx.done         = done_r;
    assign kx.key_valid    = valid_r;
endmodule
